div: RTL and testbench
======================

# div

Sequential unsigned fixed-point divider for U(WHOLE,FRACTIONAL) operands, the inverse of the `mul` block: `quotient = (dividend << FRACTIONAL_BITS) / divisor`, producing the same U format as its inputs. It is a restoring divider that resolves one quotient bit per clock and sits in the synth control path, for example for reciprocal and ratio computation. Operands enter and results leave through valid/ready handshakes.

## Interface
- `TOTAL_BITS`, 16, operand and result width
- `FRACTIONAL_BITS`, 8, fractional bits of every operand and of the result
- Derived, not overridable: `DIV_BITS = TOTAL_BITS + FRACTIONAL_BITS`, the iteration count and internal quotient width

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operands present
- `in_ready`  out  1  block can accept operands
- `dividend`  in  TOTAL_BITS  U operand (numerator)
- `divisor`  in  TOTAL_BITS  U operand (denominator)
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes the result
- `quotient`  out  TOTAL_BITS  U result
- `overflow`  out  1  result saturated because the quotient exceeds the range
- `div_by_zero`  out  1  divisor was 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready=1`.
  - Accept when `in_valid & in_ready`. Latch the divisor, load the dividend as `{dividend, FRACTIONAL_BITS'0}`, clear the remainder, set the counter to `DIV_BITS-1`.
  - If the divisor is 0, go to DONE with `quotient='1`, `div_by_zero=1`, `overflow=0`. Otherwise go to RUN.
- RUN: `in_ready=0`. Each cycle does one restoring step:
  - remainder = {remainder, dividend MSB}; shift the dividend left.
  - If remainder ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - The counter decrements. The step at counter 0 is the last step, after which the FSM goes to DONE.
- Result on entering DONE:
  - If `q[DIV_BITS-1:TOTAL_BITS]` is nonzero, set `quotient='1` and `overflow=1`.
  - Otherwise `quotient=q[TOTAL_BITS-1:0]` with truncation; the rounding option is under Configuration.
- DONE: `out_valid=1`. `quotient` and the flags stay stable until `out_ready`, then the FSM returns to IDLE.
- No new operand is accepted until the result is consumed: one operation in flight, no bypass.
- Intermediate widths: remainder is TOTAL_BITS+1, internal quotient is DIV_BITS. Nothing truncates silently.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE, `in_ready=1`, `out_valid=0`, `quotient=0`, `overflow=0`, `div_by_zero=0`. The counter and datapath registers clear, and any in-flight operation is discarded.
- Latency: accept edge → `out_valid` high after DIV_BITS+1 edges (25 with the defaults). Divide-by-zero → `out_valid` high at the next edge.
- Throughput: one result per DIV_BITS+2 cycles with `out_ready` held high.
- `out_ready` asserted while `out_valid=0` is ignored. `in_valid` asserted while `in_ready=0` is ignored; its data is not latched.
- Flags are valid only while `out_valid=1`, and hold their values until the next result.

## Configuration
- `DIV_ROUND_EN` defined: round to nearest, halves rounding up.
  - Using the final remainder r, if 2·r ≥ divisor then increment `quotient`.
  - The increment is computed combinationally on DONE entry, so it adds no latency.
  - An increment from `'1` saturates at `'1` and sets `overflow=1`.
- Undefined: the quotient truncates toward zero, consistent with `mul` truncation.

## Structure
- `fixed_pkg` holds:
  - the default `TOTAL_BITS` and `FRACTIONAL_BITS`;
  - the FSM state enum `div_state_t`;
  - a `fixed_t` typedef for the default U(8,8) word.
- Sub-module `div_step` is the purely combinational restoring step:
  - inputs: remainder, incoming bit, divisor;
  - outputs: next remainder, quotient bit.

## Test plan
- 0x0300 / 0x0200 → `quotient`=0x0180, both flags 0, `out_valid` exactly 25 cycles after accept.
- 0x0200 / 0x0300 → 0x00AA without `DIV_ROUND_EN`, 0x00AB with it. 0x0100 / 0x0300 → 0x0055 in both builds.
- 0x1234 / 0x0000 → 0xFFFF, `div_by_zero`=1, `overflow`=0, `out_valid` the cycle after accept.
- 0x8000 / 0x0001 → 0xFFFF, `overflow`=1. 0x00FF / 0x0100 → 0x00FF, no overflow.
- Back-pressure: `out_ready` low for 5 cycles after `out_valid` → `quotient` and the flags held stable, `in_ready` stays 0 and a second `in_valid` is ignored. Raising `out_ready` returns the block to IDLE, and the queued operands are then accepted.
- Assert `reset` at iteration 10 of RUN → all outputs return to their reset values immediately. A following 0x0300 / 0x0200 yields 0x0180 correctly.

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared definitions for the unsigned fixed-point arithmetic blocks.
//   DEFAULT_TOTAL_BITS      default word width of a U(WHOLE,FRACTIONAL) operand
//   DEFAULT_FRACTIONAL_BITS default number of fractional bits
//   div_state_t             state encoding of the sequential divider FSM
//   fixed_t                 default U(8,8) word
package fixed_pkg;

  localparam int DEFAULT_TOTAL_BITS      = 16;
  localparam int DEFAULT_FRACTIONAL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  typedef logic [DEFAULT_TOTAL_BITS-1:0] fixed_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in   current partial remainder (TOTAL_BITS+1 bits)
//   bit_in   next dividend bit shifted into the remainder
//   divisor  divisor (TOTAL_BITS bits)
//   rem_out  partial remainder after the trial subtraction
//   q_bit    quotient bit produced by this step
module div_step #(
  parameter int TOTAL_BITS = 16
) (
  input  logic [TOTAL_BITS:0]   rem_in,
  input  logic                  bit_in,
  input  logic [TOTAL_BITS-1:0] divisor,
  output logic [TOTAL_BITS:0]   rem_out,
  output logic                  q_bit
);

  logic [TOTAL_BITS+1:0] trial;
  logic [TOTAL_BITS:0]   diff;

  // Shift the next dividend bit into the remainder and try the subtraction.
  // The trial is kept one bit wider than the remainder so nothing is lost
  // even if the remainder MSB were ever set.
  always_comb begin
    trial = {rem_in, bit_in};
    diff  = trial[TOTAL_BITS:0] - {1'b0, divisor};
    if (trial >= {2'b00, divisor}) begin
      q_bit   = 1'b1;
      rem_out = diff;
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[TOTAL_BITS:0];
    end
  end

endmodule

// File: rtl/div.sv
// div: sequential unsigned fixed-point divider,
//   quotient = (dividend << FRACTIONAL_BITS) / divisor, same U format as inputs.
// Restoring algorithm, one quotient bit per clock, valid/ready on both sides.
// Optional build macro: DIV_ROUND_EN (round to nearest, halves up); when it
// is undefined the quotient truncates toward zero.
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   in_valid / in_ready      operand handshake
//   dividend, divisor        U operands
//   out_valid / out_ready    result handshake
//   quotient                 U result (saturates to all ones)
//   overflow                 quotient did not fit and was saturated
//   div_by_zero              divisor was zero
module div
  import fixed_pkg::*;
#(
  parameter int TOTAL_BITS      = DEFAULT_TOTAL_BITS,
  parameter int FRACTIONAL_BITS = DEFAULT_FRACTIONAL_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] dividend,
  input  logic [TOTAL_BITS-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] quotient,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int DIV_BITS = TOTAL_BITS + FRACTIONAL_BITS;
  localparam int CNT_W    = $clog2(DIV_BITS);

  div_state_t            state_q, state_d;
  logic [DIV_BITS-1:0]   dvd_q;
  logic [TOTAL_BITS-1:0] dsr_q;
  logic [TOTAL_BITS:0]   rem_q;
  logic [DIV_BITS-1:0]   q_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [TOTAL_BITS:0]   rem_nxt;
  logic                  q_bit;
  logic [DIV_BITS:0]     q_wide;
  logic                  last_step;
  logic [TOTAL_BITS-1:0] res_quot;
  logic                  res_ovf;
`ifdef DIV_ROUND_EN
  logic                  round_up;
`endif

  div_step #(.TOTAL_BITS(TOTAL_BITS)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIV_BITS-1]),
    .divisor (dsr_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // q_wide carries one spare top bit; it is always zero after DIV_BITS
  // shifts from a cleared register, so including it in the overflow test
  // is harmless and keeps every bit of the quotient register in use.
  assign q_wide    = {q_q, q_bit};
  assign last_step = (cnt_q == '0);

  // Final result as it will be registered on the last RUN step: saturate
  // when the integer part overflows the output word, optionally round.
  always_comb begin
    res_quot = q_wide[TOTAL_BITS-1:0];
    res_ovf  = |q_wide[DIV_BITS:TOTAL_BITS];
`ifdef DIV_ROUND_EN
    round_up = ({rem_nxt, 1'b0} >= {2'b00, dsr_q});
    if (!res_ovf && round_up) begin
      if (&res_quot) begin
        res_ovf = 1'b1;
      end else begin
        res_quot = res_quot + 1'b1;
      end
    end
`endif
    if (res_ovf) begin
      res_quot = '1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. A zero divisor skips RUN entirely.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one restoring step per RUN cycle,
  // result and flags registered on the last step and held through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dsr_q <= divisor;
            dvd_q <= {dividend, {FRACTIONAL_BITS{1'b0}}};
            rem_q <= '0;
            q_q   <= '0;
            cnt_q <= CNT_W'(DIV_BITS - 1);
            if (divisor == '0) begin
              quotient    <= '1;
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q <= rem_nxt;
          q_q   <= q_wide[DIV_BITS-1:0];
          dvd_q <= {dvd_q[DIV_BITS-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            quotient    <= res_quot;
            overflow    <= res_ovf;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the div fixed-point divider.
// Expected quotients are hand-computed as (dividend << 8) / divisor for the
// default U(8,8) format; the rounding build is selected by DIV_ROUND_EN.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

`ifdef DIV_ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  div dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands in IDLE and let the next rising edge accept them.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic waitResult(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] q,
                             input logic ov, input logic dz);
    checkOutput({tag, "_quotient"}, {16'b0, quotient}, {16'b0, q});
    checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, ov});
    checkOutput({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, dz});
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_cleared"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input int lat,
                       input logic [15:0] q, input logic ov, input logic dz);
    applyStimulus(a, b);
    waitResult(tag, lat);
    checkResult(tag, q, ov, dz);
    releaseResult(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkResult("reset", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    runOp("d300_200", 16'h0300, 16'h0200, 25, 16'h0180, 1'b0, 1'b0);
    runOp("d200_300", 16'h0200, 16'h0300, 25, ROUND ? 16'h00AB : 16'h00AA, 1'b0, 1'b0);
    runOp("d100_300", 16'h0100, 16'h0300, 25, 16'h0055, 1'b0, 1'b0);
    runOp("dzero",    16'h1234, 16'h0000, 1,  16'hFFFF, 1'b0, 1'b1);
    runOp("d0ff_100", 16'h00FF, 16'h0100, 25, 16'h00FF, 1'b0, 1'b0);
    runOp("d8000_1",  16'h8000, 16'h0001, 25, 16'hFFFF, 1'b1, 1'b0);

    // Back-pressure: hold the result while a second operand waits.
    applyStimulus(16'h0300, 16'h0200);
    waitResult("bp_first", 25);
    dividend = 16'h0100;
    divisor  = 16'h0300;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkResult("bp_hold", 16'h0180, 1'b0, 1'b0);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_accepted", {31'b0, in_ready}, 32'd0);
    waitResult("bp_second", 25);
    checkResult("bp_second", 16'h0055, 1'b0, 1'b0);
    releaseResult("bp_second");

    // Leave overflow set, then reset in the middle of RUN.
    runOp("pre_reset", 16'h8000, 16'h0001, 25, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'h0100, 16'h0300);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("midrun_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrun_out_valid", {31'b0, out_valid}, 32'd0);
    checkResult("midrun", 16'h0000, 1'b0, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    runOp("post_reset", 16'h0300, 16'h0200, 25, 16'h0180, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
